acc_out_buffer_drain: RTL and testbench
=======================================

Name: acc_out_buffer_drain

Overview:
- Read-side controller for one accumulation output buffer bank.
- After the PE array finishes accumulating a tile, the drain reads `length` consecutive 16-bit partial sums from the bank SRAM, starting at `base_addr`.
- Each word is post-processed (optional ReLU, rounding arithmetic right shift, saturation to `out_width`) and streamed out on a valid/ready interface toward the activation writeback path.
- A 3-entry skid FIFO absorbs the 1-cycle SRAM read latency under backpressure.

Parameters:
- buffer_width, 16, bank word width (signed two's complement)
- buffer_depth, 8192, bank words
- buffer_addr_width, clogb2(buffer_depth) = 13, bank address width
- out_width, 8, output data width (signed)
- len_width, 14, width of length field (max buffer_depth words)
- shift_width, 4, width of shift amount

Ports:
- clk  input  1  clock; all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  launch a drain; sampled only in IDLE
- base_addr  input  buffer_addr_width  first bank address; captured on start
- length  input  len_width  number of words; captured on start
- shift  input  shift_width  right-shift amount 0..15; captured on start
- relu_en  input  1  clamp negatives to 0 before shifting; captured on start
- rEn  output  1  bank read enable
- rAddr  output  buffer_addr_width  bank read address
- buffer_out  input  buffer_width  bank read data, valid the cycle after rEn
- out_data  output  out_width  processed word
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- busy  output  1  high in RUN and FLUSH
- done  output  1  one-cycle pulse at drain completion

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rEn=0, rAddr=0, out_valid=0, out_data=0, busy=0, done=0.
  - FIFO is emptied, the in-flight flag and the issue counter are cleared.
  - Reset mid-drain aborts the drain; no done is generated.
- States:
  - IDLE: start=1 captures the parameters and goes to RUN. If length=0, go to DONE instead.
  - RUN: issue reads. When issued count reaches length, go to FLUSH.
  - FLUSH: no reads. When FIFO is empty and no read is in flight, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
  - start is ignored outside IDLE.
- Read issue (RUN):
  - rEn=1 when (FIFO occupancy + in-flight) < 3.
  - rAddr = base_addr + issued count, mod buffer_depth (natural wrap, e.g. base 8190, len 4 -> 8190, 8191, 0, 1).
  - rEn and rAddr are registered. Each issue sets in-flight for exactly one cycle.
  - buffer_out is captured into the FIFO on the edge ending the cycle after rEn.
- Latency:
  - start sampled at edge k -> rEn=1 after edge k -> data captured at edge k+2 -> out_valid=1 after edge k+2.
  - With out_ready held high: one word per cycle, no bubbles.
- FIFO:
  - 3 entries; out_valid = FIFO non-empty; out_data = head.
  - Pop on out_valid && out_ready. Simultaneous push and pop keeps occupancy unchanged.
  - The issue rule guarantees no overflow. An overflow is a design error (assertion).
- Arithmetic, applied before FIFO push, so the head is registered:
  - x = signed buffer_out.
  - If relu_en and x<0, x=0.
  - If shift>0: y = (x + 2^(shift-1)) >>> shift, computed at buffer_width+1 bits (no overflow). If shift=0: y = x.
  - out_data = y saturated to signed out_width range: >127 -> 127, <-128 -> -128.
- Output ordering: words emerge in address order; no reordering or drops.
- The drain must not run while the accumulation writer targets the same bank. This is a system-level rule; the drain does not check it.

Test Plan:
- base=0, len=4, shift=0, relu=0, bank [5,-3,127,128], out_ready=1 -> out 5,-3,127,127; first out_valid 2 edges after start; done once after last pop.
- base=8190, len=4 -> rAddr sequence 8190, 8191, 0, 1; four outputs in order.
- shift=4, relu=1, words [-100, 24, 8, 32767] -> 0, 2 (24+8=32>>4), 1 (8+8=16>>4), 127 (saturated).
- len=10, out_ready toggling 1,0,0,1 pattern -> all 10 words delivered exactly once in order; rEn never issued when occupancy+in-flight=3; out_data stable while out_valid && !out_ready.
- len=0 -> no rEn; done pulse in the cycle after start; busy stays 0.
- rst_n asserted during RUN with 3 words pending -> outputs zero immediately, no done; a new start then drains correctly from scratch.

Source files
------------

// File: rtl/acc_out_buffer_drain.sv
// Read-side drain for one accumulation output buffer bank.
// Issues `length` reads from `base_addr` upward with address wrap. Each word
// returned by the bank is post-processed (optional ReLU, rounding arithmetic
// right shift, saturation) and pushed into a 3-entry skid FIFO whose head
// drives a valid/ready stream.

module acc_out_buffer_drain #(
    parameter int buffer_width      = 16,
    parameter int buffer_depth      = 8192,
    parameter int buffer_addr_width = $clog2(buffer_depth),
    parameter int out_width         = 8,
    parameter int len_width         = 14,
    parameter int shift_width       = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [buffer_addr_width-1:0] base_addr,
    input  logic [len_width-1:0]         length,
    input  logic [shift_width-1:0]       shift,
    input  logic                         relu_en,
    output logic                         rEn,
    output logic [buffer_addr_width-1:0] rAddr,
    input  logic [buffer_width-1:0]      buffer_out,
    output logic [out_width-1:0]         out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int SAT_HI_I = (2 ** (out_width - 1)) - 1;
    localparam int SAT_LO_I = -(2 ** (out_width - 1));
    localparam logic signed [buffer_width:0] SAT_HI = (buffer_width + 1)'(SAT_HI_I);
    localparam logic signed [buffer_width:0] SAT_LO = (buffer_width + 1)'(SAT_LO_I);
    localparam logic [out_width-1:0] OUT_MAX = {1'b0, {(out_width - 1){1'b1}}};
    localparam logic [out_width-1:0] OUT_MIN = {1'b1, {(out_width - 1){1'b0}}};

    // ReLU, rounding arithmetic right shift at buffer_width+1 bits, saturation.
    function automatic logic [out_width-1:0] post_proc(
        input logic [buffer_width-1:0] din,
        input logic                    relu,
        input logic [shift_width-1:0]  sh
    );
        logic signed [buffer_width:0] x;
        logic signed [buffer_width:0] rnd;
        logic signed [buffer_width:0] y;
        logic [out_width-1:0]         res;
        x = $signed({din[buffer_width-1], din});
        if (relu && din[buffer_width-1]) begin
            x = '0;
        end else begin
            x = x;
        end
        if (sh != {shift_width{1'b0}}) begin
            rnd = $signed({{buffer_width{1'b0}}, 1'b1} << (sh - {{(shift_width-1){1'b0}}, 1'b1}));
            y   = (x + rnd) >>> sh;
        end else begin
            rnd = '0;
            y   = x;
        end
        if (y > SAT_HI) begin
            res = OUT_MAX;
        end else if (y < SAT_LO) begin
            res = OUT_MIN;
        end else begin
            res = y[out_width-1:0];
        end
        return res;
    endfunction

    // Advance a pointer over the three FIFO slots.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    state_t                         state_r;
    state_t                         state_nxt_s;
    logic [buffer_addr_width-1:0]   base_r;
    logic [len_width-1:0]           len_r;
    logic [shift_width-1:0]         shift_r;
    logic                           relu_r;
    logic [len_width-1:0]           issued_r;
    logic [len_width-1:0]           issued_nxt_s;
    logic                           ren_r;
    logic [buffer_addr_width-1:0]   raddr_r;
    logic [buffer_addr_width-1:0]   raddr_nxt_s;
    logic                           inflight_r;
    logic                           busy_r;
    logic                           done_r;
    logic                           issue_s;
    logic                           busy_nxt_s;
    logic                           done_nxt_s;
    logic                           room_s;

    logic [out_width-1:0]           fifo_mem_r [0:2];
    logic [1:0]                     wr_ptr_r;
    logic [1:0]                     rd_ptr_r;
    logic [1:0]                     count_r;
    logic [1:0]                     count_nxt_s;
    logic                           push_s;
    logic                           pop_s;
    logic [out_width-1:0]           head_s;

    // FIFO handshake: data lands one cycle after the read was issued.
    always_comb begin
        push_s      = inflight_r;
        pop_s       = (count_r != 2'd0) && out_ready;
        count_nxt_s = count_r;
        if (push_s && !pop_s) begin
            count_nxt_s = count_r + 2'd1;
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - 2'd1;
        end else begin
            count_nxt_s = count_r;
        end
        // Words held after this edge plus the read still outstanding must leave a slot.
        room_s = ({1'b0, count_nxt_s} + {2'b00, ren_r}) < 3'd3;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = (length == {len_width{1'b0}}) ? ST_DONE : ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issued_r == len_r) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if ((count_r == 2'd0) && !inflight_r && !ren_r) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_FLUSH;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output logic: read issue decision and next values of the status outputs.
    always_comb begin
        issue_s      = 1'b0;
        raddr_nxt_s  = raddr_r;
        issued_nxt_s = issued_r;
        case (state_r)
            ST_IDLE: begin
                if (start && (length != {len_width{1'b0}})) begin
                    issue_s      = 1'b1;
                    raddr_nxt_s  = base_addr;
                    issued_nxt_s = {{(len_width-1){1'b0}}, 1'b1};
                end else begin
                    issued_nxt_s = {len_width{1'b0}};
                end
            end
            ST_RUN: begin
                if ((issued_r < len_r) && room_s) begin
                    issue_s      = 1'b1;
                    raddr_nxt_s  = base_r + issued_r[buffer_addr_width-1:0];
                    issued_nxt_s = issued_r + {{(len_width-1){1'b0}}, 1'b1};
                end else begin
                    issue_s = 1'b0;
                end
            end
            default: begin
                issue_s = 1'b0;
            end
        endcase
        busy_nxt_s = (state_nxt_s == ST_RUN) || (state_nxt_s == ST_FLUSH);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // Registered control outputs, issue counter and captured drain parameters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ren_r      <= 1'b0;
            raddr_r    <= '0;
            inflight_r <= 1'b0;
            issued_r   <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            base_r     <= '0;
            len_r      <= '0;
            shift_r    <= '0;
            relu_r     <= 1'b0;
        end else begin
            ren_r      <= issue_s;
            raddr_r    <= raddr_nxt_s;
            inflight_r <= ren_r;
            issued_r   <= issued_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            if ((state_r == ST_IDLE) && start) begin
                base_r  <= base_addr;
                len_r   <= length;
                shift_r <= shift;
                relu_r  <= relu_en;
            end else begin
                base_r  <= base_r;
                len_r   <= len_r;
                shift_r <= shift_r;
                relu_r  <= relu_r;
            end
        end
    end

    // Skid FIFO storage and pointers; words are processed before they are stored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem_r[0] <= '0;
            fifo_mem_r[1] <= '0;
            fifo_mem_r[2] <= '0;
            wr_ptr_r      <= 2'd0;
            rd_ptr_r      <= 2'd0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= post_proc(buffer_out, relu_r, shift_r);
                wr_ptr_r             <= ptr_inc(wr_ptr_r);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            count_r <= count_nxt_s;
        end
    end

    // Head-of-FIFO select.
    always_comb begin
        case (rd_ptr_r)
            2'd0:    head_s = fifo_mem_r[0];
            2'd1:    head_s = fifo_mem_r[1];
            2'd2:    head_s = fifo_mem_r[2];
            default: head_s = '0;
        endcase
    end

    assign rEn       = ren_r;
    assign rAddr     = raddr_r;
    assign out_valid = (count_r != 2'd0);
    assign out_data  = head_s;
    assign busy      = busy_r;
    assign done      = done_r;

    acc_out_buffer_drain_chk u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (pop_s),
        .count (count_r)
    );

endmodule

// Overflow guard for the skid FIFO.
module acc_out_buffer_drain_chk (
    input logic       clk,
    input logic       rst_n,
    input logic       push,
    input logic       pop,
    input logic [1:0] count
);

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && (count == 2'd3)))
        else $error("acc_out_buffer_drain: skid fifo overflow");

endmodule

// File: tb/tb_acc_out_buffer_drain.sv
// Directed bench for acc_out_buffer_drain with a behavioural bank SRAM.
module tb_acc_out_buffer_drain;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [12:0] base_addr;
    logic [13:0] length;
    logic [3:0]  shift;
    logic        relu_en;
    logic        rEn;
    logic [12:0] rAddr;
    logic [15:0] buffer_out;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [15:0] bank [0:8191];
    logic [12:0] addr_q [$];
    logic [7:0]  out_q [$];
    int done_cnt, done_cyc, last_pop_cyc, first_valid_cyc, start_cyc;
    int issued_n, popped_n, occ_viol, stab_viol;
    bit busy_seen;

    acc_out_buffer_drain dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .shift      (shift),
        .relu_en    (relu_en),
        .rEn        (rEn),
        .rAddr      (rAddr),
        .buffer_out (buffer_out),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Edge counter for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Bank SRAM: one-cycle read latency.
    always @(posedge clk) if (rEn) buffer_out <= bank[rAddr];

    // Runs one drain, recording everything observed at negedges until a few cycles after done.
    task automatic do_drain(input logic [12:0] b, input int n, input logic [3:0] sh,
                            input logic rl, input int mode);
        bit pat [4];
        bit prev_hold;
        logic [7:0] prev_data;
        int tail;
        bit finished;
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
        addr_q.delete(); out_q.delete();
        done_cnt = 0; done_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
        issued_n = 0; popped_n = 0; occ_viol = 0; stab_viol = 0; busy_seen = 1'b0;
        prev_hold = 1'b0; prev_data = 8'h00; tail = 0; finished = 1'b0;
        @(posedge clk); #1;
        base_addr = b; length = 14'(n); shift = sh; relu_en = rl; start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        for (int i = 0; i < 400 && !finished; i++) begin
            @(negedge clk);
            if (rEn) begin addr_q.push_back(rAddr); issued_n++; end
            if (busy) busy_seen = 1'b1;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (prev_hold && (!out_valid || out_data !== prev_data)) stab_viol++;
            prev_hold = out_valid && !out_ready;
            prev_data = out_data;
            if (out_valid && out_ready) begin
                out_q.push_back(out_data); popped_n++; last_pop_cyc = cyc;
            end
            if (issued_n - popped_n > 3) occ_viol++;
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (done_cnt > 0) tail++;
            if (tail > 4) finished = 1'b1;
            @(posedge clk); #1;
            out_ready = (mode == 0) ? 1'b1 : pat[(i + 1) % 4];
        end
        checks++;
        if (!finished) begin
            errors++;
            $display("FAIL drain_timeout: got done_cnt=%0d required a done pulse", done_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; shift = '0;
        relu_en = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (rEn !== 1'b0) begin errors++; $display("FAIL reset_rEn: got %b required 0", rEn); end
        checks++; if (rAddr !== 13'd0) begin errors++; $display("FAIL reset_rAddr: got %0d required 0", rAddr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h required 00", out_data); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b required 00", busy, done); end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp [4];
        bank[0] = 16'd5; bank[1] = 16'hFFFD; bank[2] = 16'd127; bank[3] = 16'd128;
        exp[0] = 8'h05; exp[1] = 8'hFD; exp[2] = 8'h7F; exp[3] = 8'h7F;
        do_drain(13'd0, 4, 4'd0, 1'b0, 0);
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL basic_count: got %0d required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin errors++; $display("FAIL basic_data[%0d]: got %h required %h", i, out_q[i], exp[i]); end
        end
        checks++; if (first_valid_cyc - start_cyc != 2) begin errors++; $display("FAIL basic_latency: got %0d required 2", first_valid_cyc - start_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d required 1", done_cnt); end
        checks++; if (done_cyc <= last_pop_cyc) begin errors++; $display("FAIL basic_done_after_pop: got done %0d last pop %0d", done_cyc, last_pop_cyc); end
        checks++; if (last_pop_cyc - first_valid_cyc != 3) begin errors++; $display("FAIL basic_no_bubbles: got span %0d required 3", last_pop_cyc - first_valid_cyc); end
    endtask

    task automatic test_wrap();
        logic [12:0] ea [4];
        logic [7:0]  ed [4];
        bank[8190] = 16'd10; bank[8191] = 16'd20; bank[0] = 16'd30; bank[1] = 16'd40;
        ea[0] = 13'd8190; ea[1] = 13'd8191; ea[2] = 13'd0; ea[3] = 13'd1;
        ed[0] = 8'd10; ed[1] = 8'd20; ed[2] = 8'd30; ed[3] = 8'd40;
        do_drain(13'd8190, 4, 4'd0, 1'b0, 0);
        checks++; if (addr_q.size() != 4) begin errors++; $display("FAIL wrap_addr_count: got %0d required 4", addr_q.size()); end
        for (int i = 0; i < 4 && i < addr_q.size(); i++) begin
            checks++;
            if (addr_q[i] !== ea[i]) begin errors++; $display("FAIL wrap_addr[%0d]: got %0d required %0d", i, addr_q[i], ea[i]); end
        end
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== ed[i]) begin errors++; $display("FAIL wrap_data[%0d]: got %0d required %0d", i, out_q[i], ed[i]); end
        end
    endtask

    task automatic test_shift_relu();
        logic [7:0] exp [4];
        bank[100] = 16'hFF9C; bank[101] = 16'd24; bank[102] = 16'd8; bank[103] = 16'd32767;
        exp[0] = 8'd0; exp[1] = 8'd2; exp[2] = 8'd1; exp[3] = 8'd127;
        do_drain(13'd100, 4, 4'd4, 1'b1, 0);
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL relu_count: got %0d required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin errors++; $display("FAIL relu_data[%0d]: got %h required %h", i, out_q[i], exp[i]); end
        end
    endtask

    task automatic test_round_neg();
        logic [7:0] exp [4];
        // shift=1, no ReLU: (-3+1)>>>1=-1, (-4)>>>1=-2, (-299)>>>1=-150->-128, 256>>>1=128->127
        bank[200] = 16'hFFFD; bank[201] = 16'hFFFB; bank[202] = 16'hFED4; bank[203] = 16'd255;
        exp[0] = 8'hFF; exp[1] = 8'hFE; exp[2] = 8'h80; exp[3] = 8'h7F;
        do_drain(13'd200, 4, 4'd1, 1'b0, 0);
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL round_count: got %0d required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin errors++; $display("FAIL round_data[%0d]: got %h required %h", i, out_q[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 10; i++) bank[300 + i] = 16'(3 * i - 10);
        do_drain(13'd300, 10, 4'd0, 1'b0, 1);
        checks++; if (out_q.size() != 10) begin errors++; $display("FAIL bp_count: got %0d required 10", out_q.size()); end
        for (int i = 0; i < 10 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== 8'(3 * i - 10)) begin errors++; $display("FAIL bp_data[%0d]: got %h required %h", i, out_q[i], 8'(3 * i - 10)); end
        end
        checks++; if (issued_n != 10) begin errors++; $display("FAIL bp_issued: got %0d required 10", issued_n); end
        checks++; if (occ_viol != 0) begin errors++; $display("FAIL bp_occupancy: got %0d over-issue cycles required 0", occ_viol); end
        checks++; if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable cycles required 0", stab_viol); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_count: got %0d required 1", done_cnt); end
    endtask

    task automatic test_zero_len();
        do_drain(13'd50, 0, 4'd0, 1'b0, 0);
        checks++; if (issued_n != 0) begin errors++; $display("FAIL zero_rEn: got %0d reads required 0", issued_n); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_count: got %0d required 1", done_cnt); end
        checks++; if (done_cyc != start_cyc) begin errors++; $display("FAIL zero_done_time: got %0d required %0d", done_cyc, start_cyc); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy: got 1 required 0"); end
    endtask

    task automatic test_reset_mid_run();
        int dones;
        logic [7:0] exp [4];
        dones = 0;
        for (int i = 0; i < 10; i++) bank[400 + i] = 16'(i + 1);
        @(posedge clk); #1;
        base_addr = 13'd400; length = 14'd10; shift = 4'd0; relu_en = 1'b0;
        out_ready = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) begin @(negedge clk); if (done) dones++; end
        checks++; if (out_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL rst_pending: got valid=%b busy=%b required 1 1", out_valid, busy); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || rEn !== 1'b0) begin errors++; $display("FAIL rst_mid_valid_ren: got %b %b required 0 0", out_valid, rEn); end
        checks++; if (out_data !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_data_busy: got %h %b required 00 0", out_data, busy); end
        repeat (3) begin @(negedge clk); if (done) dones++; end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); if (done) dones++; end
        checks++; if (dones != 0) begin errors++; $display("FAIL rst_no_done: got %0d done pulses required 0", dones); end
        bank[0] = 16'd5; bank[1] = 16'hFFFD; bank[2] = 16'd127; bank[3] = 16'd128;
        exp[0] = 8'h05; exp[1] = 8'hFD; exp[2] = 8'h7F; exp[3] = 8'h7F;
        do_drain(13'd0, 4, 4'd0, 1'b0, 0);
        checks++; if (out_q.size() != 4) begin errors++; $display("FAIL rst_redrain_count: got %0d required 4", out_q.size()); end
        for (int i = 0; i < 4 && i < out_q.size(); i++) begin
            checks++;
            if (out_q[i] !== exp[i]) begin errors++; $display("FAIL rst_redrain_data[%0d]: got %h required %h", i, out_q[i], exp[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rst_redrain_done: got %0d required 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_shift_relu();
        test_round_neg();
        test_backpressure();
        test_zero_len();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
